pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and stall controller for a five-stage in-order pipeline
// (IF, ID, EX, M, W).
//
// Ports:
//   clk, rst_n          single clock, asynchronous active-low reset
//   load_hazard_id      ID instruction reads the rd of a load that is in EX
//   branch_taken_ex     EX resolved a taken branch or jump
//   trap_m              M-stage instruction traps; its memory access is void
//   mem_req_m           M-stage data memory access, held while M is stalled
//   mem_ack             data memory completes the access this cycle
//   md_start_ex         EX holds a multi-cycle mul/div op, held while EX is stalled
//   md_done             one-cycle pulse: mul/div result is valid
//   stall_if..stall_m   hold the named stage register
//   flush_id            clear the IF/ID register to a NOP
//   bubble_ex/m/w       load a NOP into the ID/EX, EX/M, M/W register
//   state               current controller state code
//   stall_cycles        saturating count of cycles with stall_if asserted
//
// The stage-control outputs are combinational from state and inputs so the
// pipeline sees them in the cycle the hazard is present; only state,
// stall_cycles and the load-use bookkeeping bit are registered.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_hazard_id,
    input  logic        branch_taken_ex,
    input  logic        trap_m,
    input  logic        mem_req_m,
    input  logic        mem_ack,
    input  logic        md_start_ex,
    input  logic        md_done,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_m,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic        bubble_m,
    output logic        bubble_w,
    output logic [2:0]  state,
    output logic [31:0] stall_cycles
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned CTL_W   = 8;
    localparam int unsigned RULE_W  = STATE_W + 1 + CTL_W;

    localparam logic [STATE_W-1:0] ST_RUN      = 3'd0;
    localparam logic [STATE_W-1:0] ST_MEM_WAIT = 3'd1;
    localparam logic [STATE_W-1:0] ST_MD_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_FLUSH    = 3'd3;

    // Control vector bit order:
    // {stall_if, stall_id, stall_ex, stall_m, flush_id, bubble_ex, bubble_m, bubble_w}
    localparam logic [CTL_W-1:0] CTL_NONE  = 8'b0000_0000;
    localparam logic [CTL_W-1:0] CTL_TRAP  = 8'b0000_1110; // kill ID, EX, M
    localparam logic [CTL_W-1:0] CTL_MEM   = 8'b1111_0001; // hold IF..M, bubble into W
    localparam logic [CTL_W-1:0] CTL_MD    = 8'b1110_0010; // hold IF..EX, bubble into M
    localparam logic [CTL_W-1:0] CTL_KILL2 = 8'b0000_1100; // kill ID, EX
    localparam logic [CTL_W-1:0] CTL_LU    = 8'b1100_0100; // hold IF, ID, bubble into EX

    localparam logic [XLEN-1:0] CNT_MAX = {XLEN{1'b1}};

    logic [STATE_W-1:0] state_q, state_d;
    logic [XLEN-1:0]    stall_cycles_q, stall_cycles_d;
    logic               lu_q, lu_d;
    logic [CTL_W-1:0]   ctl_c;
    logic [CTL_W-1:0]   ctl_gated;

    // Normal-operation priority list; returns {next_state, load_use_fired, ctl}.
    // Trap and mem can be skipped when the caller has already settled them.
    function automatic logic [RULE_W-1:0] run_rules(
        input logic skip_trap,
        input logic skip_mem,
        input logic trap,
        input logic mreq,
        input logic mack,
        input logic mds,
        input logic mdd,
        input logic br,
        input logic lh,
        input logic lu_prev
    );
        logic [RULE_W-1:0] r;
        r = {ST_RUN, 1'b0, CTL_NONE};
        if (trap && !skip_trap) begin
            r = {ST_FLUSH, 1'b0, CTL_TRAP};
        end else if (mreq && !mack && !skip_mem) begin
            r = {ST_MEM_WAIT, 1'b0, CTL_MEM};
        end else if (mds && !mdd) begin
            r = {ST_MD_WAIT, 1'b0, CTL_MD};
        end else if (br) begin
            r = {ST_RUN, 1'b0, CTL_KILL2};
        end else if (lh && !lu_prev) begin
            // A load-use hazard needs exactly one stall: the cycle after, the
            // load has moved to M and forwarding covers it.
            r = {ST_RUN, 1'b1, CTL_LU};
        end
        return r;
    endfunction

    // Next-state and stage-control decode.
    always_comb begin
        state_d = ST_RUN;
        lu_d    = 1'b0;
        ctl_c   = CTL_NONE;
        case (state_q)
            ST_RUN: begin
                {state_d, lu_d, ctl_c} = run_rules(1'b0, 1'b0, trap_m, mem_req_m,
                    mem_ack, md_start_ex, md_done, branch_taken_ex, load_hazard_id, lu_q);
            end
            ST_MEM_WAIT: begin
                if (!mem_ack) begin
                    state_d = ST_MEM_WAIT;
                    ctl_c   = CTL_MEM;
                end else begin
                    // Release cycle: the M instruction is known good and done.
                    {state_d, lu_d, ctl_c} = run_rules(1'b1, 1'b1, trap_m, mem_req_m,
                        mem_ack, md_start_ex, md_done, branch_taken_ex, load_hazard_id, lu_q);
                end
            end
            ST_MD_WAIT: begin
                if (!md_done) begin
                    // EX stays held. M is free: a pending memory access there
                    // stalls M too and moves the bubble to W; a trap in M only
                    // needs the M bubble, which the hold already supplies.
                    state_d = ST_MD_WAIT;
                    if (mem_req_m && !mem_ack && !trap_m) begin
                        ctl_c = CTL_MEM;
                    end else begin
                        ctl_c = CTL_MD;
                    end
                end else begin
                    {state_d, lu_d, ctl_c} = run_rules(1'b0, 1'b0, trap_m, mem_req_m,
                        mem_ack, md_start_ex, md_done, branch_taken_ex, load_hazard_id, lu_q);
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
                ctl_c   = CTL_KILL2;
            end
            default: begin
                state_d = ST_RUN;
                ctl_c   = CTL_NONE;
            end
        endcase
    end

    // Reset must silence the stage controls immediately, not at the next edge.
    assign ctl_gated = rst_n ? ctl_c : CTL_NONE;

    assign {stall_if, stall_id, stall_ex, stall_m,
            flush_id, bubble_ex, bubble_m, bubble_w} = ctl_gated;

    // Saturating stall counter.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (ctl_gated[CTL_W-1] && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + XLEN'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            stall_cycles_q <= '0;
            lu_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            lu_q           <= lu_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. A driver applies directed
// and random stimulus, runs a reference model that thinks in terms of
// "how many front stages are frozen" and "how many front registers are
// killed", and queues the expected response; a monitor compares on the
// falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_hazard_id, branch_taken_ex, trap_m, mem_req_m;
    logic        mem_ack, md_start_ex, md_done;
    logic        stall_if, stall_id, stall_ex, stall_m;
    logic        flush_id, bubble_ex, bubble_m, bubble_w;
    logic [2:0]  state;
    logic [31:0] stall_cycles;

    pipe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_hazard_id (load_hazard_id),
        .branch_taken_ex(branch_taken_ex),
        .trap_m         (trap_m),
        .mem_req_m      (mem_req_m),
        .mem_ack        (mem_ack),
        .md_start_ex    (md_start_ex),
        .md_done        (md_done),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .stall_m        (stall_m),
        .flush_id       (flush_id),
        .bubble_ex      (bubble_ex),
        .bubble_m       (bubble_m),
        .bubble_w       (bubble_w),
        .state          (state),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    // Input bundle order: lh br trap mreq mack mds mdd
    typedef struct packed {
        logic lh, br, trap, mreq, mack, mds, mdd;
    } in_t;

    typedef struct packed {
        logic [7:0]  ctl;
        logic [2:0]  st;
        logic [31:0] cnt;
    } exp_t;

    localparam int MS_RUN = 0, MS_MEMW = 1, MS_MDW = 2, MS_FLUSH = 3;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_state = MS_RUN;
    bit          m_lu = 1'b0;
    logic [31:0] m_cnt = '0;
    in_t         prev_in = '0;
    logic [7:0]  prev_ctl = '0;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, got, want);
        end
    endfunction

    // Priority of hazards while running: trap, memory wait, mul/div wait,
    // taken branch, load-use (once per hazard).
    task automatic run_model(input in_t i, input bit no_trap, input bit no_mem,
                             output int frz, output int kil, output int nxt, output bit lu);
        frz = 0; kil = 0; nxt = MS_RUN; lu = 1'b0;
        if (i.trap && !no_trap) begin
            kil = 3; nxt = MS_FLUSH;
        end else if (i.mreq && !i.mack && !no_mem) begin
            frz = 4; nxt = MS_MEMW;
        end else if (i.mds && !i.mdd) begin
            frz = 3; nxt = MS_MDW;
        end else if (i.br) begin
            kil = 2;
        end else if (i.lh && !m_lu) begin
            frz = 2; lu = 1'b1;
        end
    endtask

    task automatic model_cycle(input in_t i, output exp_t e);
        int frz, kil, nxt;
        bit lu;
        frz = 0; kil = 0; nxt = MS_RUN; lu = 1'b0;
        case (m_state)
            MS_RUN:   run_model(i, 1'b0, 1'b0, frz, kil, nxt, lu);
            MS_MEMW:  if (!i.mack) begin frz = 4; nxt = MS_MEMW; end
                      else run_model(i, 1'b1, 1'b1, frz, kil, nxt, lu);
            MS_MDW:   if (!i.mdd) begin
                          nxt = MS_MDW;
                          frz = (i.mreq && !i.mack && !i.trap) ? 4 : 3;
                      end else run_model(i, 1'b0, 1'b0, frz, kil, nxt, lu);
            default:  begin kil = 2; nxt = MS_RUN; end
        endcase
        // Frozen stages 1..frz (IF=1 .. M=4); the register right after the
        // last frozen stage gets the bubble. Killed registers count from IF/ID.
        e.ctl = {frz >= 1, frz >= 2, frz >= 3, frz >= 4,
                 kil >= 1, (frz == 2) || (kil >= 2), (frz == 3) || (kil >= 3), frz == 4};
        e.st  = 3'(m_state);
        e.cnt = m_cnt;
        if (frz >= 1 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        m_state = nxt;
        m_lu    = lu;
    endtask

    // Called at posedge+1: apply inputs, predict, then advance one cycle.
    task automatic drive(input in_t i);
        exp_t e;
        {load_hazard_id, branch_taken_ex, trap_m, mem_req_m, mem_ack, md_start_ex, md_done} = i;
        model_cycle(i, e);
        exp_q.push_back(e);
        prev_in  = i;
        prev_ctl = e.ctl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {load_hazard_id, branch_taken_ex, trap_m, mem_req_m, mem_ack, md_start_ex, md_done} = 7'b1011010;
        #1;
        chk("rst_ctl", 32'({stall_if, stall_id, stall_ex, stall_m, flush_id, bubble_ex, bubble_m, bubble_w}), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", stall_cycles, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_state = MS_RUN;
        m_lu    = 1'b0;
        m_cnt   = '0;
        prev_in = '0;
        prev_ctl = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ctl", 32'({stall_if, stall_id, stall_ex, stall_m, flush_id, bubble_ex, bubble_m, bubble_w}), 32'(e.ctl));
            chk("state", 32'(state), 32'(e.st));
            chk("stall_cycles", stall_cycles, e.cnt);
        end
    end

    initial begin
        in_t i;
        rst_n = 1'b0;
        {load_hazard_id, branch_taken_ex, trap_m, mem_req_m, mem_ack, md_start_ex, md_done} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_ctl", 32'({stall_if, stall_id, stall_ex, stall_m, flush_id, bubble_ex, bubble_m, bubble_w}), 32'd0);
        chk("init_state", 32'(state), 32'd0);
        chk("init_cnt", stall_cycles, 32'd0);
        rst_n = 1'b1;

        // Memory wait of three cycles, then ack.
        repeat (3) drive(in_t'(7'b0001000));
        drive(in_t'(7'b0001100));
        chk("memwait_cnt", stall_cycles, 32'd3);
        chk("memwait_state", 32'(state), 32'd0);

        // Mul/div with a trap in M during the wait, done on the fifth cycle.
        drive(in_t'(7'b0000010));
        drive(in_t'(7'b0010010));
        repeat (2) drive(in_t'(7'b0000010));
        drive(in_t'(7'b0000011));
        chk("md_cnt", stall_cycles, 32'd7);

        // Branch beats load-use in the same cycle.
        drive(in_t'(7'b1100000));
        chk("br_lu_cnt", stall_cycles, 32'd7);

        // Load-use held high for two cycles stalls only once.
        repeat (2) drive(in_t'(7'b1000000));
        drive(in_t'(7'b0000000));
        chk("lu_once_cnt", stall_cycles, 32'd8);

        // Trap beats a pending memory access, then one flush cycle.
        drive(in_t'(7'b0011000));
        drive(in_t'(7'b0000000));
        drive(in_t'(7'b0000000));

        // Reset in the middle of a memory wait.
        repeat (2) drive(in_t'(7'b0001000));
        do_reset();
        drive(in_t'(7'b0000000));

        // Unreachable state code returns to RUN with controls silent.
        force dut.state_q = 3'd5;
        {load_hazard_id, branch_taken_ex, trap_m, mem_req_m, mem_ack, md_start_ex, md_done} = 7'b1111010;
        #1;
        release dut.state_q;
        #1;
        chk("bad_state_ctl", 32'({stall_if, stall_id, stall_ex, stall_m, flush_id, bubble_ex, bubble_m, bubble_w}), 32'd0);
        chk("bad_state_code", 32'(state), 32'd5);
        @(posedge clk);
        #1;
        chk("bad_state_recover", 32'(state), 32'd0);
        m_state = MS_RUN;
        m_lu    = 1'b0;

        // Counter saturation from a preloaded value near the top.
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cycles_q;
        m_cnt = 32'hFFFF_FFFD;
        repeat (5) drive(in_t'(7'b0001000));
        drive(in_t'(7'b0001100));
        chk("sat_cnt", stall_cycles, 32'hFFFF_FFFF);
        do_reset();

        // Random traffic obeying the hold rules for mem_req_m and md_start_ex.
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            i.lh   = ($urandom_range(0, 3) == 0);
            i.br   = ($urandom_range(0, 5) == 0);
            i.trap = ($urandom_range(0, 11) == 0);
            i.mack = ($urandom_range(0, 1) == 0);
            i.mdd  = !prev_in.mdd && ($urandom_range(0, 3) == 0);
            i.mreq = prev_ctl[4] ? prev_in.mreq : ($urandom_range(0, 3) == 0);
            i.mds  = prev_ctl[5] ? prev_in.mds  : ($urandom_range(0, 7) == 0);
            drive(i);
        end
        drive(in_t'(7'b0000000));

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
